// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package   : pipe_pkg
// Purpose   : Shared definitions for the MIPS-32 pipeline sequencer:
//             sequencer state encoding, the hard-wired zero register number,
//             the NOP instruction word and the operand-match helper.
// Ports     : none (package)
// Revision  : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   localparam logic [4:0]  REG_ZERO  = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // A load destination only matters when it names a real register.
   function automatic logic dest_hits(input logic [4:0] dest, input logic [4:0] src);
      return (dest != REG_ZERO) && (dest == src);
   endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : hazard_ctrl_if
// Purpose   : Bundles the hazard inputs from ID/EXE/MEM and the pipeline
//             register controls produced by hazard_ctrl.
// Signals   : id_rs, id_rt, id_uses_rt, id_is_muldiv   - ID-stage instruction
//             exe_mem_read, exe_rt                      - EXE-stage load
//             mem_branch_taken                          - MEM-stage branch
//             pc_write, ifid_write, ifid_flush,
//             idexe_write, idexe_bubble, exemem_bubble  - pipeline controls
//             md_start, md_abort, md_busy               - mult/div control
//             stall_cycles [CNT_W]                      - perf counter
// Modports  : master (pipeline side), slave (sequencer side)
// Revision  : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             id_is_muldiv;
   logic             exe_mem_read;
   logic [4:0]       exe_rt;
   logic             mem_branch_taken;

   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idexe_write;
   logic             idexe_bubble;
   logic             exemem_bubble;
   logic             md_start;
   logic             md_abort;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_is_muldiv,
             exe_mem_read, exe_rt, mem_branch_taken,
      input  pc_write, ifid_write, ifid_flush, idexe_write, idexe_bubble,
             exemem_bubble, md_start, md_abort, md_busy, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_is_muldiv,
             exe_mem_read, exe_rt, mem_branch_taken,
      output pc_write, ifid_write, ifid_flush, idexe_write, idexe_bubble,
             exemem_bubble, md_start, md_abort, md_busy, stall_cycles
   );
endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : hazard_ctrl
// Purpose   : Pipeline sequencer for the 5-stage MIPS-32 core. Drives the
//             write-enable / bubble / flush controls of PC, IF/ID, ID/EXE and
//             EXE/MEM for load-use stalls, taken-branch flushes resolved in
//             MEM and the multi-cycle hold of the iterative mult/div unit.
//             Keeps a saturating stall-cycle counter.
// Ports     : clock   - rising-edge clock
//             reset_n - asynchronous active-low reset
//             hz      - hazard_ctrl_if.slave (hazard inputs, pipeline controls)
// Params    : MD_LATENCY - cycles a mult/div occupies EXE (>= 2)
//             CNT_W      - width of stall_cycles (must match hz)
// Revision  : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   hazard_ctrl_if.slave  hz
);

   localparam int             MD_W    = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
   localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 2);

   state_t           state;
   state_t           next_state;
   logic [MD_W-1:0]  md_cnt;
   logic [MD_W-1:0]  next_cnt;
   logic             run_en;
   logic [CNT_W-1:0] stall_cycles;

   logic             load_use;
   logic             br;

   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idexe_write;
   logic             idexe_bubble;
   logic             exemem_bubble;
   logic             md_start;
   logic             md_abort;

   // Hazard comparator: same-cycle, zero latency.
   always_comb begin
      load_use = hz.exe_mem_read &&
                 (dest_hits(hz.exe_rt, hz.id_rs) ||
                  (hz.id_uses_rt && dest_hits(hz.exe_rt, hz.id_rt)));
      br       = hz.mem_branch_taken;
   end

   // Control decode and next-state; priority br > hold > load-use > md issue.
   always_comb begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idexe_write   = 1'b1;
      idexe_bubble  = 1'b0;
      exemem_bubble = 1'b0;
      md_start      = 1'b0;
      md_abort      = 1'b0;
      next_state    = state;
      next_cnt      = md_cnt;

      if (!run_en) begin
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         ifid_flush    = 1'b1;
         idexe_bubble  = 1'b1;
         exemem_bubble = 1'b1;
      end else if (br) begin
         ifid_flush    = 1'b1;
         idexe_bubble  = 1'b1;
         exemem_bubble = 1'b1;
         if (state == MD_BUSY) begin
            md_abort   = 1'b1;
            next_state = RUN;
            next_cnt   = '0;
         end
      end else if (state == MD_BUSY) begin
         // Every MD_BUSY cycle holds the front end; after the md_cnt==0
         // cycle the result sits in EXE and advances on the next RUN cycle,
         // giving MD_LATENCY cycles of EXE occupancy counting the issue slot.
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         idexe_write   = 1'b0;
         exemem_bubble = 1'b1;
         if (md_cnt == '0) begin
            next_state = RUN;
         end else begin
            next_cnt = md_cnt - MD_W'(1);
         end
      end else if (load_use) begin
         // The bubble removes the load from EXE, so the hazard clears itself
         // after exactly one cycle; a dependent mult/div issues afterwards.
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idexe_bubble = 1'b1;
      end else if (hz.id_is_muldiv) begin
         md_start   = 1'b1;
         next_state = MD_BUSY;
         next_cnt   = MD_LOAD;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= RUN;
         md_cnt       <= '0;
         run_en       <= 1'b0;
         stall_cycles <= '0;
      end else begin
         run_en <= 1'b1;
         if (run_en) begin
            state  <= next_state;
            md_cnt <= next_cnt;
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
               stall_cycles <= stall_cycles + CNT_W'(1);
            end
         end
      end
   end

   assign hz.pc_write      = pc_write;
   assign hz.ifid_write    = ifid_write;
   assign hz.ifid_flush    = ifid_flush;
   assign hz.idexe_write   = idexe_write;
   assign hz.idexe_bubble  = idexe_bubble;
   assign hz.exemem_bubble = exemem_bubble;
   assign hz.md_start      = md_start;
   assign hz.md_abort      = md_abort;
   assign hz.md_busy       = (state == MD_BUSY);
   assign hz.stall_cycles  = stall_cycles;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : tb_hazard_ctrl
// Purpose   : Directed self-checking bench for hazard_ctrl (MD_LATENCY=4,
//             CNT_W=3 so counter saturation is reachable).
// Ports     : none (top-level bench)
// Revision  : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int MD_LATENCY = 4;
   localparam int CNT_W      = 3;

   // Control word order: pc_write, ifid_write, ifid_flush, idexe_write,
   //                     idexe_bubble, exemem_bubble, md_start, md_abort
   localparam logic [7:0] C_NORM = 8'b1101_0000;
   localparam logic [7:0] C_RST  = 8'b0011_1100;
   localparam logic [7:0] C_LU   = 8'b0001_1000;
   localparam logic [7:0] C_MDS  = 8'b1101_0010;
   localparam logic [7:0] C_HOLD = 8'b0000_0100;
   localparam logic [7:0] C_BR   = 8'b1111_1100;
   localparam logic [7:0] C_BRAB = 8'b1111_1101;

   logic clock;
   logic reset_n;
   int   total;
   int   bad;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   hazard_ctrl #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .hz      (hz)
   );

   logic [7:0] ctrl;
   assign ctrl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idexe_write,
                  hz.idexe_bubble, hz.exemem_bubble, hz.md_start, hz.md_abort};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic md, input logic mr, input logic [4:0] ert,
                        input logic br);
      hz.id_rs            = rs;
      hz.id_rt            = rt;
      hz.id_uses_rt       = urt;
      hz.id_is_muldiv     = md;
      hz.exe_mem_read     = mr;
      hz.exe_rt           = ert;
      hz.mem_branch_taken = br;
   endtask

   // Sample half a cycle away from the rising edge.
   task automatic expect_state(input string tag, input logic [7:0] c, input logic busy,
                               input int cnt);
      @(negedge clock);
      check_val({tag, ".ctrl"},  32'(ctrl), 32'(c));
      check_val({tag, ".busy"},  32'(hz.md_busy), 32'(busy));
      check_val({tag, ".stall"}, 32'(hz.stall_cycles), 32'(cnt));
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

      // Reset state, then the first cycle after release is still stalled.
      expect_state("reset", C_RST, 1'b0, 0);
      tick;
      reset_n = 1'b1;
      expect_state("rel0", C_RST, 1'b0, 0);
      tick;

      // 1: lw $5 in EXE, ID reads rs=5 -> one stall cycle.
      drive(5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
      expect_state("lu_rs", C_LU, 1'b0, 0);
      tick;
      drive(5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_state("lu_after", C_NORM, 1'b0, 1);
      tick;

      // 2: register zero and unused rt never stall; used rt does.
      drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
      expect_state("r0", C_NORM, 1'b0, 1);
      tick;
      drive(5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
      expect_state("rt_unused", C_NORM, 1'b0, 1);
      tick;
      drive(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
      expect_state("lu_rt", C_LU, 1'b0, 1);
      tick;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

      // 3: mult/div issue, three held MD_BUSY cycles, then RUN.
      drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_state("md_issue", C_MDS, 1'b0, 2);
      tick;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_state("md_b1", C_HOLD, 1'b1, 2);
      tick;
      expect_state("md_b2", C_HOLD, 1'b1, 3);
      tick;
      expect_state("md_b3", C_HOLD, 1'b1, 4);
      tick;
      expect_state("md_done", C_NORM, 1'b0, 5);
      tick;

      // 4: taken branch in the second MD_BUSY cycle aborts the mult/div.
      drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_state("md2_issue", C_MDS, 1'b0, 5);
      tick;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_state("md2_b1", C_HOLD, 1'b1, 5);
      tick;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      expect_state("md2_abort", C_BRAB, 1'b1, 6);
      tick;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_state("md2_run", C_NORM, 1'b0, 6);
      tick;

      // 5: branch beats load-use; no abort outside MD_BUSY.
      drive(5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
      expect_state("br_lu", C_BR, 1'b0, 6);
      tick;

      // Dependent mult/div stalls first, issues next cycle; counter saturates.
      drive(5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0);
      expect_state("lu_md", C_LU, 1'b0, 6);
      tick;
      drive(5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_state("lu_md_iss", C_MDS, 1'b0, 7);
      tick;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_state("sat_b1", C_HOLD, 1'b1, 7);
      tick;
      expect_state("sat_b2", C_HOLD, 1'b1, 7);
      tick;

      // 6: reset mid-MD_BUSY takes effect immediately, no abort pulse.
      reset_n = 1'b0;
      #1;
      check_val("rst_mid.ctrl",  32'(ctrl), 32'(C_RST));
      check_val("rst_mid.busy",  32'(hz.md_busy), 32'd0);
      check_val("rst_mid.stall", 32'(hz.stall_cycles), 32'd0);
      tick;
      reset_n = 1'b1;
      expect_state("rst_rel0", C_RST, 1'b0, 0);
      tick;
      expect_state("rst_run", C_NORM, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hazard_ctrl
`default_nettype wire
